// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the 4-digit 7-segment scanner: active-low glyphs,
// scan FSM encoding and the all-anodes-off pattern.
package seven_seg_scanner_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Active-low enable for a single digit position.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        anode_sel = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Glyph lookup.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode driver with guard slots, leading-zero
// blanking, saturation blink and per-frame input latching.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 4
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       si,
    input  logic       blink_src,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int SLOT_MAX = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
    localparam int CNT_W    = (SLOT_MAX > 2) ? $clog2(SLOT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             load_s;

    logic [3:0][3:0]  dig_q;
    logic             si_q, blz_q;
    logic             blink_s1_q, blink_s2_q;

    logic [3:0]       blank_s;
    logic [6:0]       glyph_s;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    bcd_to_seg u_dec (
        .bcd_i (dig_q[idx_q]),
        .seg_o (glyph_s)
    );

    // Slot sequencing: the shared counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        load_s  = 1'b0;
        case (state_q)
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_GUARD;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    load_s  = (idx_q == 2'd3);
                end else begin
                    state_d = ST_SHOW;
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // Blanking chain runs from the most significant digit downwards.
    always_comb begin
        blank_s    = 4'b0000;
        blank_s[3] = blz_q && (dig_q[3] == 4'd0);
        blank_s[2] = blank_s[3] && (dig_q[2] == 4'd0);
        blank_s[1] = blank_s[2] && (dig_q[1] == 4'd0);
        blank_s[0] = 1'b0;
    end

    // Next output values derived from the current slot.
    always_comb begin
        an_d  = ANODES_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == ST_SHOW) begin
            seg_d = glyph_s;
            dp_d  = !(si_q && (idx_q == 2'd0));
            if (!blank_s[idx_q] && !(si_q && !blink_s2_q)) begin
                an_d = anode_sel(idx_q);
            end else begin
                an_d = ANODES_OFF;
            end
        end else begin
            an_d = ANODES_OFF;
        end
    end

    // FSM, counter, index and the blink synchroniser.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_GUARD;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            blink_s1_q <= 1'b0;
            blink_s2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            blink_s1_q <= blink_src;
            blink_s2_q <= blink_s1_q;
        end
    end

    // Frame shadow registers, refreshed only at the frame boundary.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_q <= '0;
            si_q  <= 1'b0;
            blz_q <= 1'b0;
        end else if (load_s) begin
            dig_q <= {bcd3, bcd2, bcd1, bcd0};
            si_q  <= si;
            blz_q <= blank_lz;
        end else begin
            dig_q <= dig_q;
            si_q  <= si_q;
            blz_q <= blz_q;
        end
    end

    // Output registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= ANODES_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= load_s;
        end
    end

endmodule
